// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forward-select encodings, the in-flight slot record and the decode action set.
package pipe_ctrl_pkg;

  // Execute-stage operand mux selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // r0 is hard-wired to zero: it never creates a hazard and is never forwarded
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register address width carried in a tracking slot
  localparam int SLOT_AW = 5;

  // Multiply occupancy counter width (covers MUL_LAT up to 15)
  localparam int CNT_W = 4;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               wr;
    logic               ld;
    logic               mul;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  // What happens to the instruction in decode this cycle
  typedef enum logic [1:0] {
    ACT_ISSUE    = 2'd0,
    ACT_MUL_HOLD = 2'd1,
    ACT_LOAD_USE = 2'd2,
    ACT_FLUSH    = 2'd3
  } action_e;

  // A slot only produces a value worth tracking if it really writes a non-zero register
  function automatic logic slot_writes(input logic valid, input logic wr,
                                       input logic [SLOT_AW-1:0] rd);
    return valid && wr && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the pipeline datapath (master) and the
// hazard controller (slave): decoded instruction fields in, control out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_a;
  logic [REG_AW-1:0] id_rs_b;
  logic              id_use_a;
  logic              id_use_b;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_is_load;
  logic              id_is_mul;
  logic              ex_branch_taken;

  logic              stall_if;
  logic              bubble_ex;
  logic              flush_id;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mul_busy;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
           id_rd, id_wr_en, id_is_load, id_is_mul, ex_branch_taken,
    input  stall_if, bubble_ex, flush_id, fwd_a, fwd_b, mul_busy
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
           id_rd, id_wr_en, id_is_load, id_is_mul, ex_branch_taken,
    output stall_if, bubble_ex, flush_id, fwd_a, fwd_b, mul_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_cmp.sv
// Per-operand comparator: checks one decode source against the producers
// in EX and MEM and derives the load-use flag and the forward select.
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              ex_wr_eff,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_ld,
  input  logic              mem_wr_eff,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              match_ex,
  output logic              match_mem,
  output logic              load_use,
  output logic [1:0]        fwd_sel
);

  // Producer matches; the effective-write flags already exclude r0
  always_comb begin
    match_ex  = use_src && ex_wr_eff  && (src == ex_rd);
    match_mem = use_src && mem_wr_eff && (src == mem_rd);
    load_use  = match_ex && ex_ld;
  end

  // EX result wins over MEM data; a load in EX cannot be forwarded yet
  always_comb begin
    fwd_sel = FWD_RF;
    if (match_ex && !ex_ld) begin
      fwd_sel = FWD_EXMEM;
    end else if (match_mem) begin
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage integer pipeline.
// Tracks destinations in EX/MEM/WB, decides issue/stall/bubble/flush for the
// decode instruction and registers the EX operand forward selects.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int REG_AW  = 5
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave hz
);

  slot_t ex_slot_reg,  ex_slot_next;
  slot_t mem_slot_reg, mem_slot_next;
  slot_t wb_slot_reg,  wb_slot_next;

  logic [CNT_W-1:0] mul_cnt_reg, mul_cnt_next;
  logic             mul_busy_reg, mul_busy_next;
  logic [1:0]       fwd_a_reg, fwd_a_next;
  logic [1:0]       fwd_b_reg, fwd_b_next;

  action_e action;
  logic    ex_wr_eff;
  logic    mem_wr_eff;
  logic    mul_hold;
  logic    load_use_hit;

  logic [REG_AW-1:0] src_addr  [2];
  logic              src_use   [2];
  logic              match_ex  [2];
  logic              match_mem [2];
  logic              lu_hit    [2];
  logic [1:0]        fwd_sel   [2];

  assign src_addr[0] = hz.id_rs_a;
  assign src_addr[1] = hz.id_rs_b;
  assign src_use[0]  = hz.id_use_a;
  assign src_use[1]  = hz.id_use_b;

  assign ex_wr_eff  = slot_writes(ex_slot_reg.valid,  ex_slot_reg.wr,  ex_slot_reg.rd);
  assign mem_wr_eff = slot_writes(mem_slot_reg.valid, mem_slot_reg.wr, mem_slot_reg.rd);

  // One comparator per source operand (0 = A, 1 = B)
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
        .src        (src_addr[gi]),
        .use_src    (src_use[gi]),
        .ex_wr_eff  (ex_wr_eff),
        .ex_rd      (ex_slot_reg.rd),
        .ex_ld      (ex_slot_reg.ld),
        .mem_wr_eff (mem_wr_eff),
        .mem_rd     (mem_slot_reg.rd),
        .match_ex   (match_ex[gi]),
        .match_mem  (match_mem[gi]),
        .load_use   (lu_hit[gi]),
        .fwd_sel    (fwd_sel[gi])
      );
    end
  endgenerate

  // Priority decision for the decode instruction: branch, multiply, load-use, issue
  always_comb begin
    mul_hold     = mul_busy_reg && (mul_cnt_reg != CNT_W'(1));
    load_use_hit = hz.id_valid && (lu_hit[0] || lu_hit[1]);
    action       = ACT_ISSUE;
    if (hz.ex_branch_taken) begin
      action = ACT_FLUSH;
    end else if (mul_hold) begin
      action = ACT_MUL_HOLD;
    end else if (load_use_hit) begin
      action = ACT_LOAD_USE;
    end
  end

  assign hz.stall_if  = (action == ACT_MUL_HOLD) || (action == ACT_LOAD_USE);
  assign hz.bubble_ex = (action == ACT_FLUSH)    || (action == ACT_LOAD_USE);
  assign hz.flush_id  = (action == ACT_FLUSH);
  assign hz.fwd_a     = fwd_a_reg;
  assign hz.fwd_b     = fwd_b_reg;
  assign hz.mul_busy  = mul_busy_reg;

  // Next slot contents, multiply counter and forward selects for each action
  always_comb begin
    ex_slot_next  = ex_slot_reg;
    mem_slot_next = ex_slot_reg;
    wb_slot_next  = mem_slot_reg;
    fwd_a_next    = fwd_a_reg;
    fwd_b_next    = fwd_b_reg;
    mul_cnt_next  = (mul_cnt_reg != '0) ? (mul_cnt_reg - CNT_W'(1)) : '0;

    unique case (action)
      ACT_FLUSH: begin
        // Squash decode; any multiply occupancy ends because EX advances
        ex_slot_next = SLOT_NONE;
        fwd_a_next   = FWD_RF;
        fwd_b_next   = FWD_RF;
        mul_cnt_next = '0;
      end
      ACT_MUL_HOLD: begin
        // The multiply stays in EX; nothing new enters MEM
        ex_slot_next  = ex_slot_reg;
        mem_slot_next = SLOT_NONE;
      end
      ACT_LOAD_USE: begin
        ex_slot_next = SLOT_NONE;
        fwd_a_next   = FWD_RF;
        fwd_b_next   = FWD_RF;
      end
      default: begin
        if (hz.id_valid) begin
          ex_slot_next.valid = 1'b1;
          ex_slot_next.rd    = hz.id_rd;
          ex_slot_next.wr    = hz.id_wr_en;
          ex_slot_next.ld    = hz.id_is_load;
          ex_slot_next.mul   = hz.id_is_mul;
          fwd_a_next         = fwd_sel[0];
          fwd_b_next         = fwd_sel[1];
          if (hz.id_is_mul) begin
            mul_cnt_next = CNT_W'(MUL_LAT);
          end
        end else begin
          ex_slot_next = SLOT_NONE;
          fwd_a_next   = FWD_RF;
          fwd_b_next   = FWD_RF;
        end
      end
    endcase

    mul_busy_next = (mul_cnt_next != '0);
  end

  // State registers; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_slot_reg  <= SLOT_NONE;
      mem_slot_reg <= SLOT_NONE;
      wb_slot_reg  <= SLOT_NONE;
      mul_cnt_reg  <= '0;
      mul_busy_reg <= 1'b0;
      fwd_a_reg    <= FWD_RF;
      fwd_b_reg    <= FWD_RF;
    end else begin
      ex_slot_reg  <= ex_slot_next;
      mem_slot_reg <= mem_slot_next;
      wb_slot_reg  <= wb_slot_next;
      mul_cnt_reg  <= mul_cnt_next;
      mul_busy_reg <= mul_busy_next;
      fwd_a_reg    <= fwd_a_next;
      fwd_b_reg    <= fwd_b_next;
    end
  end

  // WB and some slot fields are tracked for completeness but not consumed here
  logic unused_bits;
  assign unused_bits = ^{wb_slot_reg, mem_slot_reg.ld, mem_slot_reg.mul, ex_slot_reg.mul,
                         match_ex[0], match_ex[1], match_mem[0], match_mem[1]};

endmodule
